phase_unwrap_avg: RTL

- Sits directly downstream of the CORDIC phase FSM and consumes each `phi`/`done` result.
- Removes the ±half-turn wrap so phase accumulates without bound, giving a continuous phase for fringe tracking.
- Also outputs a boxcar average of the unwrapped phase over 2^LOG2_AVG samples for the slow control loop.
- There is no backpressure; results are pulse-qualified.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/boxcar_avg.sv | 64 ++++++
 rtl/phase_unwrap_avg.sv | 119 +++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC phase scaling, unwrap state type and the half-turn fold helper.
// Combinational helpers only; no latency, no flow control.
package cordic_pkg;

    localparam int CORDIC_PHASE_WIDTH = 24;
    localparam int CORDIC_HALF_TURN   = 8388607;

    typedef enum logic {
        FIRST = 1'b0,
        TRACK = 1'b1
    } unwrap_state_t;

    typedef logic signed [63:0] wide_t;

    // Fold a raw phase step back into [-half, +half]; exactly +/-half is kept as is.
    function automatic wide_t wrap_delta(input wide_t raw, input wide_t half);
        wide_t span;
        wide_t res;
        span = half + half;
        res  = raw;
        if (raw > half) begin
            res = raw - span;
        end else if (raw < -half) begin
            res = raw + span;
        end
        return res;
    endfunction

endpackage

// File: rtl/boxcar_avg.sv
// Power-of-two block averager: floor mean of each 2^LOG2_N input pulses.
// Latency 1 cycle after the last sample of a block; no backpressure, pulse in/pulse out.
module boxcar_avg #(
    parameter int WIDTH  = 40,
    parameter int LOG2_N = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    in_vld_i,
    input  logic signed [WIDTH-1:0] in_dat_i,
    output logic signed [WIDTH-1:0] avg_dat_o,
    output logic                    avg_vld_o
);
    localparam int            SW   = WIDTH + LOG2_N;
    localparam int            CW   = LOG2_N + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

    logic signed [SW-1:0]    sum_q, sum_d, sum_next;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] avg_q, avg_d;
    logic                    avg_vld_q, avg_vld_d;

    always_comb begin
        sum_next  = sum_q + SW'(in_dat_i);
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        if (clear_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (in_vld_i) begin
            // Closing sample: emit the mean and restart so the next pulse opens a new block.
            if (cnt_q == LAST) begin
                sum_d     = '0;
                cnt_d     = '0;
                avg_d     = WIDTH'(sum_next >>> LOG2_N);
                avg_vld_d = 1'b1;
            end else begin
                sum_d = sum_next;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sum_q     <= '0;
            cnt_q     <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
        end
    end

    assign avg_dat_o = avg_q;
    assign avg_vld_o = avg_vld_q;

endmodule

// File: rtl/phase_unwrap_avg.sv
// Unwraps CORDIC phase into an unbounded accumulator and block-averages it.
// Latency 2 cycles (unwrapped) / 3 cycles (average) after valid_i; no backpressure, pulse-qualified.
module phase_unwrap_avg
    import cordic_pkg::*;
#(
    parameter int PHASE_WIDTH = CORDIC_PHASE_WIDTH,
    parameter int HALF_TURN   = CORDIC_HALF_TURN,
    parameter int OUT_WIDTH   = 40,
    parameter int LOG2_AVG    = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic signed [PHASE_WIDTH-1:0] phi_i,
    input  logic                          valid_i,
    input  logic                          clear_i,
    output logic signed [OUT_WIDTH-1:0]   unwrapped_o,
    output logic                          unwrapped_valid_o,
    output logic signed [OUT_WIDTH-1:0]   avg_o,
    output logic                          avg_valid_o,
    output logic                          overflow_o
);
    localparam int DW = PHASE_WIDTH + 1;

    unwrap_state_t                 state_q, state_d;
    logic signed [PHASE_WIDTH-1:0] phi_prev_q, phi_prev_d;
    logic signed [DW-1:0]          delta_q, delta_d, raw_delta, wrapped;
    logic                          s1_vld_q, s1_vld_d;
    logic                          s1_first_q, s1_first_d;
    logic signed [OUT_WIDTH-1:0]   acc_q, acc_d, acc_sum, delta_ext;
    logic                          acc_vld_q, acc_vld_d;
    logic                          ovf_q, ovf_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= FIRST;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (valid_i)      state_d = TRACK;
        else if (clear_i) state_d = FIRST;
    end

    // A sample taken alongside clear starts fresh history, whatever the state.
    always_comb begin
        s1_first_d = clear_i || (state_q == FIRST);
    end

    always_comb begin
        raw_delta  = {phi_i[PHASE_WIDTH-1], phi_i} - {phi_prev_q[PHASE_WIDTH-1], phi_prev_q};
        wrapped    = DW'(wrap_delta(wide_t'(raw_delta), wide_t'(HALF_TURN)));
        phi_prev_d = valid_i ? phi_i : phi_prev_q;
        s1_vld_d   = valid_i;
        delta_d    = delta_q;
        if (valid_i) begin
            delta_d = s1_first_d ? {phi_i[PHASE_WIDTH-1], phi_i} : wrapped;
        end
    end

    always_comb begin
        delta_ext = {{(OUT_WIDTH-DW){delta_q[DW-1]}}, delta_q};
        acc_sum   = acc_q + delta_ext;
        acc_d     = acc_q;
        acc_vld_d = 1'b0;
        ovf_d     = ovf_q;
        if (clear_i) begin
            ovf_d = 1'b0;
        end else if (s1_vld_q) begin
            acc_vld_d = 1'b1;
            if (s1_first_q) begin
                acc_d = delta_ext;
            end else begin
                acc_d = acc_sum;
                if ((acc_q[OUT_WIDTH-1] == delta_ext[OUT_WIDTH-1]) &&
                    (acc_sum[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1])) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            phi_prev_q <= '0;
            delta_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            acc_q      <= '0;
            acc_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            phi_prev_q <= phi_prev_d;
            delta_q    <= delta_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            acc_q      <= acc_d;
            acc_vld_q  <= acc_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    boxcar_avg #(
        .WIDTH  (OUT_WIDTH),
        .LOG2_N (LOG2_AVG)
    ) u_boxcar (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (clear_i),
        .in_vld_i  (acc_vld_q),
        .in_dat_i  (acc_q),
        .avg_dat_o (avg_o),
        .avg_vld_o (avg_valid_o)
    );

    assign unwrapped_o       = acc_q;
    assign unwrapped_valid_o = acc_vld_q;
    assign overflow_o        = ovf_q;

endmodule
